// File: rtl/pll_clken_gen.sv
// Fractional clock-enable generator gated by a settled PLL lock flag.
// Optional lock-loss statistics counter: define PLL_CLKEN_STATS_EN.
module pll_clken_gen #(
  parameter int CHANNELS      = 2,
  parameter int ACC_W         = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      locked,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic                      resync,
  output logic [CHANNELS-1:0]       clken,
  output logic                      ready,
  output logic                      lost_lock,
  output logic [7:0]                loss_cnt
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic locked_m;
  logic locked_s;

  logic load;
  logic clr;
  logic step;
  logic lose;

  logic [ACC_W-1:0] acc     [CHANNELS];
  logic [ACC_W-1:0] inc_reg [CHANNELS];
  logic [ACC_W:0]   sum     [CHANNELS];

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Lock loss is tested before resync so it always wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    clr       = 1'b0;
    step      = 1'b0;
    lose      = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          load      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          clr       = 1'b1;
          lose      = 1'b1;
        end else if (resync) begin
          load = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc_reg[i]};
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]     <= '0;
        inc_reg[i] <= '0;
      end
      clken <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load || clr) begin
          acc[i] <= '0;
        end else if (step) begin
          acc[i] <= sum[i][ACC_W-1:0];
        end
        if (load) begin
          inc_reg[i] <= inc[i*ACC_W +: ACC_W];
        end
        clken[i] <= step & sum[i][ACC_W];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      ready     <= (state_nxt == RUN);
      lost_lock <= lose;
    end
  end

`ifdef PLL_CLKEN_STATS_EN
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (lose && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen with a queue-based scoreboard.
// Expected loss counts follow PLL_CLKEN_STATS_EN when defined.
module tb_pll_clken_gen;

  localparam int CH = 2;
  localparam int AW = 16;
  localparam int SC = 16;
  // two sync flops, one WAIT_LOCK decision edge, SC settle edges
  localparam int LOCK_LAT = 2 + 1 + SC;

`ifdef PLL_CLKEN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           locked;
  logic [CH*AW-1:0] inc;
  logic           resync;
  logic [CH-1:0]  clken;
  logic           ready;
  logic           lost_lock;
  logic [7:0]     loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  pll_clken_gen #(
    .CHANNELS(CH),
    .ACC_W(AW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .refclk(clk),
    .rst_n(rst_n),
    .locked(locked),
    .inc(inc),
    .resync(resync),
    .clken(clken),
    .ready(ready),
    .lost_lock(lost_lock),
    .loss_cnt(loss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wait_ready(input int budget, output int n,
                            output int pulses);
    n = 0;
    pulses = 0;
    do begin
      tick();
      n++;
      if (lost_lock) pulses++;
    end while (!ready && n < budget);
  endtask

  initial begin
    int          n;
    int          p;
    int          tot;
    int          c0;
    int          c1;
    logic [1:0]  patt [8];

    rst_n  = 1'b0;
    locked = 1'b0;
    resync = 1'b0;
    inc    = 32'h8000_4000;
    tick();
    tick();
    tick();
    push("rst_ready", 0);     check(32'(ready));
    push("rst_clken", 0);     check(32'(clken));
    push("rst_lost", 0);      check(32'(lost_lock));
    push("rst_loss", 0);      check(32'(loss_cnt));

    rst_n = 1'b1;
    tick();
    tick();
    push("wait_ready", 0);    check(32'(ready));

    // first lock and settle
    locked = 1'b1;
    wait_ready(60, n, p);
    push("lock_lat", LOCK_LAT); check(32'(n));

    // ch0 every 4th, ch1 every 2nd edge
    patt = '{2'b00, 2'b10, 2'b00, 2'b11,
             2'b00, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) push("run_clken", 32'(patt[i]));
    for (int i = 0; i < 8; i++) begin
      tick();
      check(32'(clken));
    end
    tick();
    push("pre_rsync", 0);     check(32'(clken));

    // resync on an edge where ch1 would otherwise carry
    inc    = 32'h2000_2000;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    push("rsync_clken", 0);   check(32'(clken));
    push("rsync_ready", 1);   check(32'(ready));
    for (int i = 1; i <= 16; i++) begin
      push("rsync_run", (i % 8 == 0) ? 32'd3 : 32'd0);
      tick();
      check(32'(clken));
    end

    // lock loss while resync is also held: loss must win
    resync = 1'b1;
    locked = 1'b0;
    tick();
    push("loss_e1_ready", 1); check(32'(ready));
    tick();
    push("loss_e2_ready", 1); check(32'(ready));
    push("loss_e2_lost", 0);  check(32'(lost_lock));
    tick();
    resync = 1'b0;
    push("loss_ready", 0);    check(32'(ready));
    push("loss_lost", 1);     check(32'(lost_lock));
    push("loss_clken", 0);    check(32'(clken));
    push("loss_cnt1", STATS); check(32'(loss_cnt));
    tick();
    push("loss_pulse_end", 0); check(32'(lost_lock));

    // abort settling at count 10
    locked = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    push("settle_ready", 0);  check(32'(ready));
    locked = 1'b0;
    tick();
    tick();
    tick();
    locked = 1'b1;
    wait_ready(60, n, p);
    push("relock_lat", LOCK_LAT); check(32'(n));

    // increments latched on entry to RUN
    n = 0;
    do begin
      tick();
      n++;
    end while (clken != 2'b11 && n < 20);
    push("latch_first", 8);   check(32'(n));

    // reset mid-run
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push("mrst_ready", 0);    check(32'(ready));
    push("mrst_clken", 0);    check(32'(clken));
    push("mrst_lost", 0);     check(32'(lost_lock));
    push("mrst_loss", 0);     check(32'(loss_cnt));
    wait_ready(60, n, p);
    push("mrst_lat", LOCK_LAT); check(32'(n));
    push("mrst_pulses", 0);   check(32'(p));

    // extreme increments over a full accumulator period
    inc    = 32'hFFFF_0000;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      c0 += int'(clken[0]);
      c1 += int'(clken[1]);
    end
    push("inc_zero", 0);      check(32'(c0));
    push("inc_max", 65535);   check(32'(c1));

    // repeated lock losses saturate the counter
    tot = 0;
    for (int k = 0; k < 300; k++) begin
      locked = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (lost_lock) tot++;
      end
      locked = 1'b1;
      wait_ready(60, n, p);
      tot += p;
    end
    push("sat_pulses", 300);  check(32'(tot));
    push("sat_cnt", STATS ? 255 : 0); check(32'(loss_cnt));
    push("sat_ready", 1);     check(32'(ready));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
